// File: rtl/fft_ctrl_pkg.sv
// Shared types and default sizing for the mod1 factor-8 FFT control stages.
package fft_ctrl_pkg;

  localparam int unsigned FFT_BLK_CYC  = 32;
  localparam int unsigned FFT_PIPE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic valid;
    logic last;
  } dl_entry_t;

endpackage

// File: rtl/vld_delay_line.sv
// Shift register of {valid, last} entries; exposes the taps one stage before
// and at the full depth.
module vld_delay_line
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = FFT_PIPE_LAT
) (
  input  logic      clk,
  input  logic      rst,
  input  dl_entry_t din,
  output dl_entry_t tap_alert,
  output dl_entry_t tap_out
);

  dl_entry_t [DEPTH-1:0] sr_q;
  dl_entry_t [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  // An entry loaded at acceptance t sits in sr_q[k-1] during cycle t+k.
  assign tap_alert = sr_q[DEPTH-2];
  assign tap_out   = sr_q[DEPTH-1];

endmodule

// File: rtl/ctrl_mod1_fac8_1.sv
// Stage-1 control: numbers beats within a frame, drives the twiddle index and
// re-times valid through the stage-1 datapath latency.
module ctrl_mod1_fac8_1
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned BLK_CYC  = FFT_BLK_CYC,
  parameter int unsigned PIPE_LAT = FFT_PIPE_LAT,
  parameter int unsigned CNT_W    = $clog2(BLK_CYC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic [CNT_W-1:0] tw_idx,
  output logic             tw_vld,
  output logic             alert_next,
  output logic             valid_out,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned DW = $clog2(PIPE_LAT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tw_idx_q, tw_idx_d;
  logic             tw_vld_q, tw_vld_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             is_last;
  dl_entry_t        dl_in, dl_alert, dl_out;

  assign is_last = (cnt_q == CNT_W'(BLK_CYC - 1));

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    cnt_d    = valid_in ? cnt_q + CNT_W'(1) : cnt_q;
    tw_idx_d = valid_in ? cnt_q : tw_idx_q;
    tw_vld_d = valid_in;
    unique case (state_q)
      IDLE: begin
        if (valid_in) state_d = RUN;
      end
      RUN: begin
        if (valid_in && is_last) begin
          state_d = DRAIN;
          drain_d = DW'(PIPE_LAT);
        end
      end
      DRAIN: begin
        // A new frame overlapping the drain restarts RUN; the delay line
        // keeps emitting the previous tail on its own.
        if (valid_in) begin
          state_d = RUN;
        end else begin
          drain_d = drain_q - DW'(1);
          if (drain_q == DW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tw_idx_q <= '0;
      tw_vld_q <= 1'b0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tw_idx_q <= tw_idx_d;
      tw_vld_q <= tw_vld_d;
      drain_q  <= drain_d;
    end
  end

  always_comb begin
    dl_in       = '0;
    dl_in.valid = valid_in;
    dl_in.last  = valid_in & is_last;
  end

  vld_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_dly (
    .clk       (clk),
    .rst       (rst),
    .din       (dl_in),
    .tap_alert (dl_alert),
    .tap_out   (dl_out)
  );

  assign tw_idx     = tw_idx_q;
  assign tw_vld     = tw_vld_q;
  assign alert_next = dl_alert.valid;
  assign valid_out  = dl_out.valid;
  assign frame_done = dl_out.valid & dl_out.last;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ctrl_mod1_fac8_1.sv
// Self-checking bench: default instance plus a PIPE_LAT=4 / BLK_CYC=8 instance,
// both checked every cycle against an event-list reference model.
module tb_ctrl_mod1_fac8_1;

  localparam int P1 = 2, B1 = 32, P2 = 4, B2 = 8;

  logic clk = 1'b0;
  logic rst, valid_in, valid_in2;
  logic [4:0] tw_idx;
  logic [2:0] tw_idx2;
  logic tw_vld, alert_next, valid_out, frame_done, busy;
  logic tw_vld2, alert_next2, valid_out2, frame_done2, busy2;

  always #5 clk = ~clk;

  ctrl_mod1_fac8_1 dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .tw_idx(tw_idx), .tw_vld(tw_vld),
    .alert_next(alert_next), .valid_out(valid_out), .frame_done(frame_done), .busy(busy)
  );

  ctrl_mod1_fac8_1 #(.BLK_CYC(B2), .PIPE_LAT(P2)) dut2 (
    .clk(clk), .rst(rst), .valid_in(valid_in2), .tw_idx(tw_idx2), .tw_vld(tw_vld2),
    .alert_next(alert_next2), .valid_out(valid_out2), .frame_done(frame_done2), .busy(busy2)
  );

  // Observed vector: {tw_vld, tw_idx[7:0], alert_next, valid_out, frame_done, busy}
  logic [12:0] obs1, obs2, e1, e2;
  assign obs1 = {tw_vld, 8'(tw_idx), alert_next, valid_out, frame_done, busy};
  assign obs2 = {tw_vld2, 8'(tw_idx2), alert_next2, valid_out2, frame_done2, busy2};

  typedef struct {
    int e;     // clock edge at which the beat was sampled
    int b;     // beat number within its frame
    bit last;
  } beat_t;

  beat_t q1[$], q2[$];
  int ecount = 0;
  int tests = 0, fails = 0;

  // Expected outputs during the cycle following edge n, from the list of
  // accepted beats since reset.
  function automatic logic [12:0] exp_vec(input beat_t q[$], input int n, input int p);
    logic vld = 1'b0, al = 1'b0, vo = 1'b0, fd = 1'b0, bz = 1'b0;
    logic [7:0] idx = '0;
    foreach (q[i]) begin
      if (q[i].e <= n) begin
        idx = 8'(q[i].b);
        bz  = !(q[i].last && n >= q[i].e + p);
      end
      if (q[i].e == n) vld = 1'b1;
      if (q[i].e == n - (p - 2)) al = 1'b1;
      if (q[i].e == n - (p - 1)) begin
        vo = 1'b1;
        fd = q[i].last;
      end
    end
    return {vld, idx, al, vo, fd, bz};
  endfunction

  task automatic step(input logic v1, input logic v2);
    beat_t bt;
    valid_in  = v1;
    valid_in2 = v2;
    @(posedge clk);
    ecount++;
    if (v1) begin
      bt.e = ecount; bt.b = q1.size() % B1; bt.last = (bt.b == B1 - 1);
      q1.push_back(bt);
    end
    if (v2) begin
      bt.e = ecount; bt.b = q2.size() % B2; bt.last = (bt.b == B2 - 1);
      q2.push_back(bt);
    end
    @(negedge clk);
    e1 = exp_vec(q1, ecount, P1);
    e2 = exp_vec(q2, ecount, P2);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; valid_in2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    q2.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (obs1 !== 13'd0 || obs2 !== 13'd0) begin
      fails++;
      $display("FAIL reset: got %b / %b want all zero", obs1, obs2);
    end
  endtask

  task automatic test_back_to_back();
    int fd_cnt = 0;
    do_reset();
    for (int i = 0; i < 38; i++) begin
      step(i < 32, 1'b0);
      fd_cnt += frame_done;
      tests++;
      if (obs1 !== e1) begin
        fails++;
        $display("FAIL b2b edge %0d: got %b want %b", ecount, obs1, e1);
      end
    end
    tests++;
    if (fd_cnt != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_summary: frame_done=%0d busy=%b want 1 and 0", fd_cnt, busy);
    end
  endtask

  task automatic test_every_other();
    int vo_cnt = 0, fd_cnt = 0;
    do_reset();
    for (int i = 0; i < 70; i++) begin
      step((i % 2 == 0) && i < 64, 1'b0);
      vo_cnt += valid_out;
      fd_cnt += frame_done;
      tests++;
      if (obs1 !== e1) begin
        fails++;
        $display("FAIL gaps edge %0d: got %b want %b", ecount, obs1, e1);
      end
    end
    tests++;
    if (vo_cnt != 32 || fd_cnt != 1) begin
      fails++;
      $display("FAIL gaps_summary: valid_out=%0d frame_done=%0d want 32 and 1", vo_cnt, fd_cnt);
    end
  endtask

  task automatic test_overlap();
    int vo_cnt = 0, fd_cnt = 0, busy_drop = 0;
    do_reset();
    for (int i = 0; i < 70; i++) begin
      step(i < 64, 1'b0);
      vo_cnt += valid_out;
      fd_cnt += frame_done;
      if (i < 65 && busy !== 1'b1) busy_drop++;
      tests++;
      if (obs1 !== e1) begin
        fails++;
        $display("FAIL overlap edge %0d: got %b want %b", ecount, obs1, e1);
      end
    end
    tests++;
    if (vo_cnt != 64 || fd_cnt != 2 || busy_drop != 0) begin
      fails++;
      $display("FAIL overlap_summary: vo=%0d fd=%0d drops=%0d want 64 2 0", vo_cnt, fd_cnt, busy_drop);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (obs1 !== 13'd0 || obs2 !== 13'd0) begin
      fails++;
      $display("FAIL async_reset: got %b / %b want all zero", obs1, obs2);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    q2.delete();
    for (int i = 0; i < 8; i++) begin
      step(i == 2, i == 2);
      tests++;
      if (obs1 !== e1 || obs2 !== e2) begin
        fails++;
        $display("FAIL post_reset edge %0d: got %b / %b want %b / %b", ecount, obs1, obs2, e1, e2);
      end
    end
  endtask

  task automatic test_single_pulse();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(i == 1, 1'b0);
      tests++;
      if (obs1 !== e1) begin
        fails++;
        $display("FAIL single edge %0d: got %b want %b", ecount, obs1, e1);
      end
    end
  endtask

  task automatic test_sweep();
    int fd_cnt = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, i < 8);
      fd_cnt += frame_done2;
      tests++;
      if (obs2 !== e2) begin
        fails++;
        $display("FAIL sweep edge %0d: got %b want %b", ecount, obs2, e2);
      end
    end
    tests++;
    if (fd_cnt != 1 || busy2 !== 1'b0) begin
      fails++;
      $display("FAIL sweep_summary: frame_done=%0d busy=%b want 1 and 0", fd_cnt, busy2);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 100) < 65, ($urandom % 100) < 55);
      tests++;
      if (obs1 !== e1 || obs2 !== e2) begin
        fails++;
        $display("FAIL random edge %0d: got %b / %b want %b / %b", ecount, obs1, obs2, e1, e2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; valid_in2 = 1'b0;
    test_reset();
    test_back_to_back();
    test_every_other();
    test_overlap();
    test_mid_reset();
    test_single_pulse();
    test_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
